// File: rtl/hwmod_rst_seq_if.sv
// Peripheral-bus bundle for the reset sequencer's status register.
// The CPU side is the master; the sequencer's register port is the slave.
interface hwmod_rst_seq_if;
   logic        per_en;
   logic [1:0]  per_we;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic [15:0] per_dout;

   modport master (
      output per_en,
      output per_we,
      output per_addr,
      output per_din,
      input  per_dout
   );

   modport slave (
      input  per_en,
      input  per_we,
      input  per_addr,
      input  per_din,
      output per_dout
   );
endinterface

// File: rtl/hwmod_rst_seq.sv
// Reset sequencer: turns VRASED/CASU violation requests into a minimum-width core
// reset, verifies the core reboots to the reset handler, and logs cause/count.
module hwmod_rst_seq #(
   parameter int          RST_CYCLES    = 16,
   parameter int          BOOT_TIMEOUT  = 64,
   parameter logic [15:0] RESET_HANDLER = 16'h0000,
   parameter logic [13:0] PER_ADDR      = 14'h0098
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              vrased_req,
   input  logic              casu_req,
   input  logic [15:0]       pc,
   hwmod_rst_seq_if.slave    bus,
   output logic              cpu_rst,
   output logic              rst_active
);

   typedef enum logic [1:0] {IDLE, HOLD, BOOT} state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(RST_CYCLES - 1);
   localparam logic [7:0] BOOT_LAST = 8'(BOOT_TIMEOUT - 1);

   state_t     state_reg, state_next;
   logic [7:0] timer_reg, timer_next;
   logic [2:0] cause_reg, cause_next;
   logic [7:0] viol_cnt_reg, viol_cnt_next;
   logic       cpu_rst_reg;

   logic       req;
   logic       addr_hit;
   logic       clr;
   logic       rd;
   logic       event_now;
   logic       timeout_now;
   logic [2:0] cause_base;
   logic [7:0] cnt_base;
   logic       unused_din;

   assign req        = vrased_req | casu_req;
   assign addr_hit   = bus.per_en && (bus.per_addr == PER_ADDR);
   assign clr        = addr_hit && (bus.per_we != 2'b00);
   assign rd         = addr_hit && (bus.per_we == 2'b00);
   assign unused_din = ^bus.per_din;

   always_comb begin
      state_next  = state_reg;
      timer_next  = timer_reg;
      event_now   = 1'b0;
      timeout_now = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req) begin
               event_now = 1'b1;
            end
         end
         HOLD: begin
            if (timer_reg != 8'd0) begin
               timer_next = timer_reg - 8'd1;
            end else if (!req) begin
               state_next = BOOT;
               timer_next = 8'd0;
            end
         end
         BOOT: begin
            timer_next = timer_reg + 8'd1;
            if (req) begin
               event_now = 1'b1;
            end else if (pc == RESET_HANDLER) begin
               state_next = IDLE;
            end else if (timer_reg == BOOT_LAST) begin
               event_now   = 1'b1;
               timeout_now = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = 8'd0;
         end
      endcase
      if (event_now) begin
         state_next = HOLD;
         timer_next = HOLD_LOAD;
      end
   end

   // A software clear lands before a same-cycle event so the event is never lost.
   always_comb begin
      cause_base    = clr ? 3'b000 : cause_reg;
      cnt_base      = clr ? 8'd0 : viol_cnt_reg;
      cause_next    = cause_base;
      viol_cnt_next = cnt_base;
      if (event_now) begin
         cause_next    = cause_base | {timeout_now, casu_req, vrased_req};
         viol_cnt_next = (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         timer_reg    <= 8'd0;
         cause_reg    <= 3'b000;
         viol_cnt_reg <= 8'd0;
         cpu_rst_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         cause_reg    <= cause_next;
         viol_cnt_reg <= viol_cnt_next;
         cpu_rst_reg  <= (state_next == HOLD);
      end
   end

   assign cpu_rst      = cpu_rst_reg;
   assign rst_active   = (state_reg != IDLE);
   assign bus.per_dout = rd ? {viol_cnt_reg, 5'b00000, cause_reg} : 16'h0000;

endmodule

// File: tb/tb_hwmod_rst_seq.sv
// Bench for hwmod_rst_seq: directed scenario table, saturation and async-reset
// sequences, then random traffic, all checked against a cycle-level behavioural model.
module tb_hwmod_rst_seq;

   localparam int          RST_CYCLES    = 16;
   localparam int          BOOT_TIMEOUT  = 64;
   localparam logic [15:0] RESET_HANDLER = 16'h0000;
   localparam logic [13:0] PER_ADDR      = 14'h0098;

   logic        clk;
   logic        reset_n;
   logic        vrased_req;
   logic        casu_req;
   logic [15:0] pc;
   logic        cpu_rst;
   logic        rst_active;

   hwmod_rst_seq_if bus ();

   hwmod_rst_seq #(
      .RST_CYCLES   (RST_CYCLES),
      .BOOT_TIMEOUT (BOOT_TIMEOUT),
      .RESET_HANDLER(RESET_HANDLER),
      .PER_ADDR     (PER_ADDR)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .vrased_req (vrased_req),
      .casu_req   (casu_req),
      .pc         (pc),
      .bus        (bus),
      .cpu_rst    (cpu_rst),
      .rst_active (rst_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: how long reset has been held, how long since release,
   // plus the software-visible cause bits and event count.
   int         m_mode;    // 0 quiet, 1 reset held, 2 waiting for reboot
   int         m_held;
   int         m_boot;
   logic [2:0] m_cause;
   int         m_cnt;

   typedef struct {
      int          vr_start;
      int          vr_len;
      int          cs_start;
      int          cs_len;
      int          wr_cycle;
      int          pc_delay;
      int          exp_width;
      int          exp_gap;
      logic [15:0] exp_read;
   } scn_t;

   scn_t scns[4];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_dout(input logic en, input logic [1:0] we,
                                             input logic [13:0] addr);
      if (en && addr == PER_ADDR && we == 2'b00)
         return {m_cnt[7:0], 5'b00000, m_cause};
      return 16'h0000;
   endfunction

   task automatic model_reset();
      m_mode  = 0;
      m_held  = 0;
      m_boot  = 0;
      m_cause = 3'b000;
      m_cnt   = 0;
   endtask

   task automatic model_tick(input logic vr, input logic cs, input logic [15:0] pcv,
                             input logic en, input logic [1:0] we, input logic [13:0] addr);
      logic req, clr, evt, to;
      req = vr | cs;
      clr = en && addr == PER_ADDR && we != 2'b00;
      evt = 1'b0;
      to  = 1'b0;
      if (m_mode == 0) begin
         evt = req;
      end else if (m_mode == 1) begin
         m_held++;
         if (m_held >= RST_CYCLES && !req) begin
            m_mode = 2;
            m_boot = 0;
         end
      end else begin
         m_boot++;
         if (req) evt = 1'b1;
         else if (pcv == RESET_HANDLER) m_mode = 0;
         else if (m_boot == BOOT_TIMEOUT) begin
            evt = 1'b1;
            to  = 1'b1;
         end
      end
      if (clr) begin
         m_cause = 3'b000;
         m_cnt   = 0;
      end
      if (evt) begin
         m_mode  = 1;
         m_held  = 0;
         m_cause = m_cause | {to, cs, vr};
         if (m_cnt < 255) m_cnt++;
      end
   endtask

   // One clock of stimulus; called at a falling edge, returns at the next one.
   task automatic step(input logic vr, input logic cs, input logic [15:0] pcv,
                       input logic en, input logic [1:0] we, input logic [13:0] addr);
      vrased_req   = vr;
      casu_req     = cs;
      pc           = pcv;
      bus.per_en   = en;
      bus.per_we   = we;
      bus.per_addr = addr;
      bus.per_din  = 16'($urandom);
      #1;
      chk("per_dout", bus.per_dout, model_dout(en, we, addr));
      @(posedge clk);
      model_tick(vr, cs, pcv, en, we, addr);
      @(negedge clk);
      chk("cpu_rst", {15'd0, cpu_rst}, {15'd0, (m_mode == 1)});
      chk("rst_active", {15'd0, rst_active}, {15'd0, (m_mode != 0)});
   endtask

   task automatic idle_step(input logic [15:0] pcv);
      step(1'b0, 1'b0, pcv, 1'b0, 2'b00, PER_ADDR);
   endtask

   task automatic do_reset();
      vrased_req   = 1'b0;
      casu_req     = 1'b0;
      pc           = 16'hFFFF;
      bus.per_en   = 1'b0;
      bus.per_we   = 2'b00;
      bus.per_addr = 14'h0000;
      bus.per_din  = 16'h0000;
      reset_n      = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic read_expect(input string name, input logic [15:0] exp);
      bus.per_en   = 1'b1;
      bus.per_we   = 2'b00;
      bus.per_addr = PER_ADDR;
      #1;
      chk(name, bus.per_dout, exp);
      bus.per_en = 1'b0;
   endtask

   task automatic run_scn(input int idx);
      scn_t s;
      int width, gap, since_fall;
      logic fell, vr, cs, wr;
      logic [15:0] pcv;
      s = scns[idx];
      width = 0;
      gap = -1;
      since_fall = -1;
      fell = 1'b0;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         vr  = (i >= s.vr_start) && (i < s.vr_start + s.vr_len);
         cs  = (i >= s.cs_start) && (i < s.cs_start + s.cs_len);
         wr  = (i == s.wr_cycle);
         pcv = (since_fall >= s.pc_delay) ? 16'h0000 : 16'hFFFF;
         step(vr, cs, pcv, wr, wr ? 2'b11 : 2'b00, PER_ADDR);
         if (!fell) begin
            if (cpu_rst) width++;
            else if (width > 0) begin
               fell = 1'b1;
               since_fall = 0;
            end
         end else begin
            since_fall++;
            if (cpu_rst && gap < 0) gap = since_fall;
         end
      end
      chk($sformatf("scn%0d_width", idx), 16'(width), 16'(s.exp_width));
      chk($sformatf("scn%0d_gap", idx), 16'(gap), 16'(s.exp_gap));
      read_expect($sformatf("scn%0d_read", idx), s.exp_read);
      $display("scenario %0d: width=%0d gap=%0d", idx, width, gap);
   endtask

   task automatic async_reset_check(input string tag);
      #2;
      reset_n      = 1'b0;
      bus.per_en   = 1'b1;
      bus.per_we   = 2'b00;
      bus.per_addr = PER_ADDR;
      #1;
      chk({tag, "_cpu_rst"}, {15'd0, cpu_rst}, 16'h0000);
      chk({tag, "_rst_active"}, {15'd0, rst_active}, 16'h0000);
      chk({tag, "_dout"}, bus.per_dout, 16'h0000);
      model_reset();
      bus.per_en = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      //            vr_s vr_l cs_s cs_l  wr   pcd  width gap  read
      scns[0] = '{0, 1, 0, 0, -1, 3, 16, -1, 16'h0101};
      scns[1] = '{0, 0, 0, 40, -1, 3, 40, -1, 16'h0102};
      scns[2] = '{0, 1, 0, 0, -1, 1000, 16, 64, 16'h0205};
      scns[3] = '{0, 1, 30, 1, 30, 3, 16, 14, 16'h0102};

      // Power-up
      do_reset();
      repeat (10) idle_step(16'hFFFF);
      chk("pwr_cpu_rst", {15'd0, cpu_rst}, 16'h0000);
      chk("pwr_rst_active", {15'd0, rst_active}, 16'h0000);
      read_expect("pwr_read", 16'h0000);
      $display("power-up done");

      for (int k = 0; k < 4; k++) run_scn(k);

      // Saturation after 300 events
      do_reset();
      for (int e = 0; e < 300; e++) begin
         step(1'b1, 1'b0, 16'h0000, 1'b0, 2'b00, PER_ADDR);
         for (int w = 0; w < 40 && rst_active; w++) idle_step(16'h0000);
      end
      read_expect("sat_read", 16'hFF01);
      $display("saturation: 300 events issued");

      // Asynchronous reset in the middle of a reset pulse
      do_reset();
      step(1'b0, 1'b1, 16'hFFFF, 1'b0, 2'b00, PER_ADDR);
      repeat (5) idle_step(16'hFFFF);
      chk("mid_hold_cpu_rst", {15'd0, cpu_rst}, 16'h0001);
      async_reset_check("async");
      repeat (3) idle_step(16'hFFFF);
      $display("async reset mid-hold done");

      // Random traffic against the model
      do_reset();
      begin
         logic vr, cs, en;
         logic [1:0] we;
         logic [13:0] addr;
         logic [15:0] pcv;
         vr = 1'b0;
         cs = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) vr = ~vr;
            if ($urandom_range(0, 19) == 0) cs = ~cs;
            if (((i / 500) % 2) == 0) pcv = 16'($urandom_range(1, 65535));
            else pcv = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
            en   = ($urandom_range(0, 5) == 0);
            we   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            addr = ($urandom_range(0, 7) == 0) ? 14'($urandom) : PER_ADDR;
            step(vr, cs, pcv, en, we, addr);
            if (i % 900 == 899) async_reset_check("rand_async");
         end
      end
      $display("random phase done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hwmod_rst_seq.md
# hwmod_rst_seq

Reset sequencer that consumes the violation requests from the VRASED and CASU monitors and drives the openMSP430 core reset. On a violation request it asserts `cpu_rst` for a guaranteed minimum pulse and records which monitor fired. It then checks that the core actually restarts at the reset handler, re-asserting reset on timeout. A small peripheral-bus register exposes the violation cause and a saturating event count to software.

## Interface
Parameters:
- `RST_CYCLES`, 16: minimum `cpu_rst` pulse width in cycles (≥1, ≤255).
- `BOOT_TIMEOUT`, 64: cycles allowed after release for `pc` to reach `RESET_HANDLER` (≥2, ≤255).
- `RESET_HANDLER`, 16'h0000: expected first-fetch PC after reset.
- `PER_ADDR`, 14'h0098: peripheral word address of the status register (byte 0x0130).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `vrased_req` in 1: level reset request from the VRASED monitor.
- `casu_req` in 1: level reset request from the CASU monitor.
- `pc` in 16: core program counter.
- `per_en` in 1: peripheral access strobe.
- `per_we` in 2: byte write enables.
- `per_addr` in 14: peripheral word address.
- `per_din` in 16: write data (ignored; any write clears).
- `per_dout` out 16: read data, combinational.
- `cpu_rst` out 1: active-high reset to the core, registered.
- `rst_active` out 1: high whenever the FSM is not in IDLE.

## Operation
- State registers: `state` (IDLE, HOLD, BOOT), 8-bit `timer`, `cause[2:0]` = {timeout, casu, vrased}, 8-bit `viol_cnt`.
- `req` = `vrased_req | casu_req`.
- Entering HOLD is an *event*:
  - `cause` ORs in {0, casu_req, vrased_req}, or sets bit 2 for a timeout.
  - `viol_cnt` increments, saturating at 255.
  - `timer` loads `RST_CYCLES-1`.
- IDLE:
  - `req` → HOLD (event).
- HOLD:
  - `cpu_rst`=1.
  - `timer` decrements while nonzero.
  - When `timer`==0 and `req`==0 → BOOT, with `timer` cleared to 0.
  - If `req` is still high at 0 → stay in HOLD, with no new event.
- BOOT:
  - `cpu_rst`=0.
  - `timer` increments each cycle.
  - Priority order, highest first: `req` → HOLD (event); `pc`==`RESET_HANDLER` → IDLE; `timer`==`BOOT_TIMEOUT-1` → HOLD (event, timeout bit).
- Status register: `per_dout` = {`viol_cnt`, 5'b0, `cause`} when `per_en` && `per_addr`==`PER_ADDR` && `per_we`==0; otherwise `per_dout` = 16'h0000.
- Clear: a write (`per_en`, address match, `per_we`≠0) zeroes `cause` and `viol_cnt`.
  - If an event occurs in the same cycle, clear applies first, then the event: `cause` = new bits only, `viol_cnt` = 1.
- Clear does not alter `state`, `timer`, or `cpu_rst`.

## Timing
- `reset_n` low: state=IDLE, `timer`=0, `cause`=0, `viol_cnt`=0, `cpu_rst`=0, `rst_active`=0, `per_dout`=0. Takes effect immediately, mid-pulse included.
- `cpu_rst` and `rst_active` are registered: both rise on the edge that samples `req` high in IDLE, so latency is one edge.
- Minimum `cpu_rst` width is `RST_CYCLES` cycles.
- Actual width is max(`RST_CYCLES`, cycles until `req` is low at `timer`==0).
- The `cpu_rst` falling edge coincides with entry to BOOT.
- Timeout:
  - Reset re-asserts on the edge after `pc` has mismatched for `BOOT_TIMEOUT` consecutive BOOT cycles.
  - `pc` matching on the last BOOT cycle → IDLE, no timeout.
- Request pulses shorter than one cycle are not guaranteed to be caught; the monitors hold requests ≥1 cycle.
- A request in HOLD extends the pulse but adds no count.

## Test plan
- Power-up: `reset_n`=0 then 1, idle 10 cycles → `cpu_rst`=0, `rst_active`=0, read at `PER_ADDR` returns 16'h0000.
- `vrased_req` 1-cycle pulse, `pc` jumps to 16'h0000 three cycles after release → `cpu_rst` high exactly 16 cycles, FSM returns to IDLE, read returns 16'h0101.
- `casu_req` held 40 cycles → `cpu_rst` high 40 cycles and falls one cycle after `req` drops, `viol_cnt`=1, read 16'h0102.
- `vrased_req` pulse, `pc` never reaches 16'h0000 → `cpu_rst` re-asserts 64 cycles after release, read 16'h0205.
- Peripheral write to `PER_ADDR` on the same edge as a new `casu_req` event → read 16'h0102.
- 300 events → `viol_cnt` saturates at 8'hFF.
- `reset_n` asserted mid-HOLD → `cpu_rst` drops asynchronously and all registers read zero.
